// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Types and constants used by both the arbiter and its starvation counter.
package wb_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned AddrW = 5;
    localparam int unsigned CntW  = 4;
    localparam int unsigned X0    = 0;

    typedef struct packed {
        logic [AddrW-1:0] reg_idx;
        logic [DataW-1:0] data;
    } wb_req_t;

    typedef enum logic {PRI_A, FORCE_B} grant_st_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: two requesters, the stall input and the register-file write port.
interface wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);

    logic              i_aValid;
    logic [ADDR_W-1:0] i_aReg;
    logic [DATA_W-1:0] i_aData;
    logic              o_aReady;
    logic              i_bValid;
    logic [ADDR_W-1:0] i_bReg;
    logic [DATA_W-1:0] i_bData;
    logic              o_bReady;
    logic              i_stall;
    logic              o_wrSig;
    logic [ADDR_W-1:0] o_wrReg;
    logic [DATA_W-1:0] o_wrData;

    modport slave (
        input  i_aValid, i_aReg, i_aData, i_bValid, i_bReg, i_bData, i_stall,
        output o_aReady, o_bReady, o_wrSig, o_wrReg, o_wrData
    );

    modport master (
        output i_aValid, i_aReg, i_aData, i_bValid, i_bReg, i_bData, i_stall,
        input  o_aReady, o_bReady, o_wrSig, o_wrReg, o_wrData
    );

endinterface

// File: rtl/wb_starve_ctr.sv
// Requester-B wait counter and two-state grant FSM; forces a B grant once B has waited MAX_WAIT.
module wb_starve_ctr
    import wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_stall,
    input  logic i_bValid,
    input  logic i_bXfer,
    output logic o_forceB
);

    localparam logic [CntW-1:0] Limit = CntW'(MAX_WAIT);

    logic [CntW-1:0] cnt_q, cnt_d;
    grant_st_e       st_q, st_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_bValid) begin
            cnt_d = '0;
        end else if (i_stall) begin
            cnt_d = cnt_q;
        end else if (i_bXfer) begin
            cnt_d = '0;
        end else if (cnt_q < Limit) begin
            cnt_d = cnt_q + 1'b1;
        end
        st_d = (cnt_d == Limit) ? FORCE_B : PRI_A;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            st_q  <= PRI_A;
        end else begin
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    assign o_forceB = (st_q == FORCE_B);

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter, A over B, with a one-cycle registered write port.
// Define WB_ARB_STARVE_EN to add the requester-B starvation limit (MAX_WAIT).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic          i_clk,
    input logic          i_reset,
    wb_arbiter_if.slave  bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("wb_arbiter: MAX_WAIT must be in 1..15");
    end

    logic force_b;
    logic can_go;
    logic a_xfer, b_xfer;

`ifdef WB_ARB_STARVE_EN
    wb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve_ctr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_stall (bus.i_stall),
        .i_bValid(bus.i_bValid),
        .i_bXfer (b_xfer),
        .o_forceB(force_b)
    );
`else
    assign force_b = 1'b0;
`endif

    assign can_go = ~i_reset & ~bus.i_stall;
    // force_b only steals the slot from A while B is actually presenting.
    assign a_xfer = can_go & bus.i_aValid & ~(force_b & bus.i_bValid);
    assign b_xfer = can_go & bus.i_bValid & (force_b | ~bus.i_aValid);

    assign bus.o_aReady = a_xfer;
    assign bus.o_bReady = b_xfer;

    logic              wr_sig_q, wr_sig_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    always_comb begin
        wr_sig_d  = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (a_xfer) begin
            wr_sig_d  = (bus.i_aReg != ADDR_W'(X0));
            wr_reg_d  = bus.i_aReg;
            wr_data_d = bus.i_aData;
        end else if (b_xfer) begin
            wr_sig_d  = (bus.i_bReg != ADDR_W'(X0));
            wr_reg_d  = bus.i_bReg;
            wr_data_d = bus.i_bData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_sig_q  <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_sig_q  <= wr_sig_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Reset also masks the write port in the cycle it is asserted, dropping an in-flight write.
    assign bus.o_wrSig  = wr_sig_q & ~i_reset;
    assign bus.o_wrReg  = i_reset ? '0 : wr_reg_q;
    assign bus.o_wrData = i_reset ? '0 : wr_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, starvation sequences, random traffic.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned MaxWait = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    wb_arbiter_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

    wb_arbiter #(
        .DATA_W  (DataW),
        .ADDR_W  (AddrW),
        .MAX_WAIT(MaxWait)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    typedef struct {
        logic             rst;
        logic             av;
        wb_req_t          a;
        logic             bv;
        wb_req_t          b;
        logic             st;
        logic             e_ar;
        logic             e_br;
        logic             e_ws;
        logic [AddrW-1:0] e_wr;
        logic [DataW-1:0] e_wd;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending write-port contents and how long B has been refused.
    logic             m_sig  = 1'b0;
    logic [AddrW-1:0] m_reg  = '0;
    logic [DataW-1:0] m_data = '0;
    int               m_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ar,
                                input logic [31:0] ad, input logic bv, input logic [4:0] br,
                                input logic [31:0] bd, input logic st, input logic ear,
                                input logic ebr, input logic ews, input logic [4:0] ewr,
                                input logic [31:0] ewd);
        vec_t v;
        v.rst = rst; v.av = av; v.a.reg_idx = ar; v.a.data = ad;
        v.bv = bv; v.b.reg_idx = br; v.b.data = bd; v.st = st;
        v.e_ar = ear; v.e_br = ebr; v.e_ws = ews; v.e_wr = ewr; v.e_wd = ewd;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit use_tab, input string tag);
        logic ea, eb, es;
        logic [AddrW-1:0] er;
        logic [DataW-1:0] ed;
        @(negedge i_clk);
        i_reset      = v.rst;
        bus.i_aValid = v.av;
        bus.i_aReg   = v.a.reg_idx;
        bus.i_aData  = v.a.data;
        bus.i_bValid = v.bv;
        bus.i_bReg   = v.b.reg_idx;
        bus.i_bData  = v.b.data;
        bus.i_stall  = v.st;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!v.rst && !v.st) begin
            if (StarveEn && v.bv && m_wait >= int'(MaxWait)) eb = 1'b1;
            else if (v.av) ea = 1'b1;
            else if (v.bv) eb = 1'b1;
        end
        es = v.rst ? 1'b0 : m_sig;
        er = v.rst ? '0 : m_reg;
        ed = v.rst ? '0 : m_data;
        chk({tag, " aReady"}, 32'(bus.o_aReady), 32'(ea));
        chk({tag, " bReady"}, 32'(bus.o_bReady), 32'(eb));
        chk({tag, " wrSig"},  32'(bus.o_wrSig),  32'(es));
        chk({tag, " wrReg"},  32'(bus.o_wrReg),  32'(er));
        chk({tag, " wrData"}, bus.o_wrData,      ed);
        if (use_tab) begin
            chk({tag, " tab aReady"}, 32'(bus.o_aReady), 32'(v.e_ar));
            chk({tag, " tab bReady"}, 32'(bus.o_bReady), 32'(v.e_br));
            chk({tag, " tab wrSig"},  32'(bus.o_wrSig),  32'(v.e_ws));
            chk({tag, " tab wrReg"},  32'(bus.o_wrReg),  32'(v.e_wr));
            chk({tag, " tab wrData"}, bus.o_wrData,      v.e_wd);
        end
        if (v.rst) begin
            m_sig = 1'b0; m_reg = '0; m_data = '0; m_wait = 0;
        end else begin
            if (ea) begin
                m_sig = (v.a.reg_idx != 0); m_reg = v.a.reg_idx; m_data = v.a.data;
            end else if (eb) begin
                m_sig = (v.b.reg_idx != 0); m_reg = v.b.reg_idx; m_data = v.b.data;
            end else begin
                m_sig = 1'b0;
            end
            if (!v.bv) m_wait = 0;
            else if (v.st) m_wait = m_wait;
            else if (eb) m_wait = 0;
            else if (m_wait < int'(MaxWait)) m_wait++;
        end
    endtask

    vec_t tab[18];
    vec_t v;

    initial begin
        i_reset      = 1'b1;
        bus.i_aValid = 1'b0;
        bus.i_aReg   = '0;
        bus.i_aData  = '0;
        bus.i_bValid = 1'b0;
        bus.i_bReg   = '0;
        bus.i_bData  = '0;
        bus.i_stall  = 1'b0;

        //            rst av ar  ad            bv br  bd     st  ear ebr ews wr  wd
        tab[0]  = mk(1, 1, 3, 32'h1,         1, 4, 32'h2, 0,  0, 0, 0, 0, 32'h0);
        tab[1]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 0, 0, 32'h0);
        tab[2]  = mk(0, 1, 3, 32'hDEADBEEF,  0, 0, 32'h0, 0,  1, 0, 0, 0, 32'h0);
        tab[3]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 1, 3, 32'hDEADBEEF);
        tab[4]  = mk(0, 1, 0, 32'h5,         0, 0, 32'h0, 0,  1, 0, 0, 3, 32'hDEADBEEF);
        tab[5]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 0, 0, 32'h5);
        tab[6]  = mk(0, 0, 0, 32'h0,         1, 7, 32'h77, 0, 0, 1, 0, 0, 32'h5);
        tab[7]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 1, 7, 32'h77);
        tab[8]  = mk(0, 1, 9, 32'hAAAA,      1, 9, 32'hBBBB, 0, 1, 0, 0, 7, 32'h77);
        tab[9]  = mk(0, 0, 0, 32'h0,         1, 9, 32'hBBBB, 0, 0, 1, 1, 9, 32'hAAAA);
        tab[10] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 1, 9, 32'hBBBB);
        tab[11] = mk(0, 1, 4, 32'h1,         1, 5, 32'h2, 1,  0, 0, 0, 9, 32'hBBBB);
        tab[12] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 0, 9, 32'hBBBB);
        tab[13] = mk(0, 1, 6, 32'h66,        0, 0, 32'h0, 0,  1, 0, 0, 9, 32'hBBBB);
        tab[14] = mk(1, 1, 6, 32'h66,        0, 0, 32'h0, 0,  0, 0, 0, 0, 32'h0);
        tab[15] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 0, 0, 32'h0);
        tab[16] = mk(0, 1, 2, 32'h22,        0, 0, 32'h0, 0,  1, 0, 0, 0, 32'h0);
        tab[17] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 0,  0, 0, 1, 2, 32'h22);

        for (int i = 0; i < 18; i++) begin
            run(tab[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Both requesters hold valid: B must be forced in every fifth slot only with the limit.
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "starve rst");
        for (int i = 0; i < 12; i++) begin
            run(mk(0, 1, 5'(i + 1), 32'(i), 1, 5'd20, 32'hB0 + 32'(i), 0, 0, 0, 0, 0, 0),
                1'b0, $sformatf("starve%0d", i));
            chk($sformatf("starve%0d bGrant", i), 32'(bus.o_bReady),
                32'(StarveEn && (i % 5 == 4)));
            chk($sformatf("starve%0d aGrant", i), 32'(bus.o_aReady),
                32'(!(StarveEn && (i % 5 == 4))));
        end

        // B waits two cycles, a three-cycle stall holds its wait, then it resumes from there.
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "hold rst");
        for (int i = 0; i < 2; i++) begin
            run(mk(0, 1, 1, 32'h10, 1, 2, 32'h20, 0, 0, 0, 0, 0, 0), 1'b0, "hold pre");
        end
        for (int i = 0; i < 3; i++) begin
            run(mk(0, 1, 1, 32'h11, 1, 2, 32'h21, 1, 0, 0, 0, 0, 0), 1'b0, "hold stall");
        end
        for (int k = 0; k < 3; k++) begin
            run(mk(0, 1, 1, 32'h12, 1, 2, 32'h22, 0, 0, 0, 0, 0, 0), 1'b0, "hold post");
            chk($sformatf("hold post%0d bGrant", k), 32'(bus.o_bReady),
                32'(StarveEn && (k == 2)));
        end

        for (int i = 0; i < 400; i++) begin
            v.rst       = ($urandom_range(31) == 0);
            v.av        = $urandom_range(1) == 1;
            v.a.reg_idx = 5'($urandom_range(7));
            v.a.data    = $urandom;
            v.bv        = $urandom_range(3) != 0;
            v.b.reg_idx = 5'($urandom_range(7));
            v.b.data    = $urandom;
            v.st        = ($urandom_range(5) == 0);
            v.e_ar = 1'b0; v.e_br = 1'b0; v.e_ws = 1'b0; v.e_wr = '0; v.e_wd = '0;
            run(v, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning writeback data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning starvation limit in cycles for requester B; legal range 1..15.
REQ-004 The block SHALL have port i_clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have ports i_aValid, i_aReg, i_aData: input, 1/ADDR_W/DATA_W, meaning the pipeline writeback request (requester A).
REQ-007 The block SHALL have port o_aReady, output, 1, meaning requester A is accepted this cycle.
REQ-008 The block SHALL have ports i_bValid, i_bReg, i_bData: input, 1/ADDR_W/DATA_W, meaning the long-latency unit writeback request (requester B).
REQ-009 The block SHALL have port o_bReady, output, 1, meaning requester B is accepted this cycle.
REQ-010 The block SHALL have port i_stall, input, 1, meaning the writeback stage is frozen.
REQ-011 The block SHALL have ports o_wrSig, o_wrReg, o_wrData: output, 1/ADDR_W/DATA_W, meaning the registered register-file write port.

Function
REQ-012 A transfer SHALL occur when valid and ready are both high in the same cycle; at most one transfer SHALL occur per cycle.
REQ-013 Ready SHALL be combinational from valid, i_stall and the wait counter; valid SHALL NOT depend on ready.
REQ-014 With i_stall high, both readies SHALL be 0, and o_wrSig SHALL be 0 on the next cycle.
REQ-015 Default priority: A over B; when only one requester is valid, that requester SHALL be granted.
REQ-016 Latency SHALL be one cycle: a transfer in cycle N drives o_wrSig/o_wrReg/o_wrData in cycle N+1 only.
REQ-017 o_wrSig SHALL be 0 in any cycle following a cycle without a transfer; o_wrReg/o_wrData SHALL hold their last values.
REQ-018 A transfer with register index 0 SHALL complete its handshake, but o_wrSig SHALL stay 0.
REQ-019 Both requesters targeting the same register SHALL be serialised; data SHALL NOT be merged, and the loser SHALL stay pending.
REQ-020 Wait counter (4 bits): +1 per cycle in which i_bValid=1, B is not granted and i_stall=0; the counter SHALL saturate at MAX_WAIT.
REQ-021 The wait counter SHALL clear on a B transfer or whenever i_bValid=0; it SHALL hold while i_stall=1.
REQ-022 When the counter equals MAX_WAIT and i_bValid=1 and i_stall=0, B SHALL be granted even if A is valid.
REQ-023 Grant state SHALL be two-state: PRI_A (counter < MAX_WAIT) and FORCE_B (counter == MAX_WAIT); FORCE_B SHALL return to PRI_A on the cycle after the B transfer.

Reset
REQ-024 While i_reset=1: o_wrSig=0, o_wrReg=0, o_wrData=0, wait counter=0, o_aReady=0, o_bReady=0.
REQ-025 Reset asserted mid-operation SHALL drop any in-flight write (no o_wrSig after reset); requesters SHALL re-present.
REQ-026 On the first cycle after reset release, normal arbitration SHALL apply.

Configuration
REQ-027 Macro WB_ARB_STARVE_EN defined: REQ-020..REQ-023 active.
REQ-028 WB_ARB_STARVE_EN undefined: strict A-over-B priority, no wait counter or FSM, MAX_WAIT ignored; all other behaviour identical.

Structure
REQ-029 Package wb_pkg SHALL hold the wb_req_t struct (reg, data), the grant-state enum (PRI_A, FORCE_B) and the X0 index constant.
REQ-030 Sub-module wb_starve_ctr SHALL implement the wait counter and FSM, and SHALL be instantiated only under WB_ARB_STARVE_EN.

Verification
REQ-031 Reset then A valid, reg=3, data=0xDEADBEEF -> o_aReady=1 same cycle; next cycle o_wrSig=1, o_wrReg=3, o_wrData=0xDEADBEEF.
REQ-032 A and B both valid continuously, MAX_WAIT=4, STARVE_EN defined -> A granted 4 cycles, B granted on cycle 5, A on cycle 6.
REQ-033 Same stimulus, STARVE_EN undefined -> B never granted while A valid; counter absent.
REQ-034 A valid, reg=0, data=0x5 -> o_aReady=1; next cycle o_wrSig=0.
REQ-035 B waiting, counter=2, i_stall=1 for 3 cycles -> readies 0, o_wrSig=0, counter held at 2; after release, counter resumes from 2.
REQ-036 Transfer in cycle N, i_reset=1 in cycle N+1 -> o_wrSig=0 in N+1, all outputs 0, counter 0.
